// File: rtl/bft_pkg.sv
// Shared BFT definitions: packet field positions/widths for the default
// 49-bit packet, the control-port address and the transmitter FSM states.
package bft_pkg;

  localparam int BFT_PACKET_W    = 49;
  localparam int BFT_PAYLOAD_W   = 32;
  localparam int BFT_ADDR_W      = 7;
  localparam int BFT_PORT_W      = 4;
  localparam int BFT_LEAF_W      = 4;

  localparam int BFT_PAYLOAD_LSB = 0;
  localparam int BFT_ZERO_POS    = 32;
  localparam int BFT_SEQ_LSB     = 33;
  localparam int BFT_PORT_LSB    = 40;
  localparam int BFT_LEAF_LSB    = 44;
  localparam int BFT_VALID_POS   = 48;

  localparam int BFT_CTRL_PORT   = 0;

  typedef enum logic [1:0] {
    ST_SEND        = 2'd0,
    ST_WAIT_CREDIT = 2'd1,
    ST_REPLAY      = 2'd2
  } bft_state_e;

endpackage

// File: rtl/bft_credit_counter.sv
// Saturating receiver-credit counter: one slot consumed per accepted word,
// returned slots added in the same cycle, never above INIT.
module bft_credit_counter #(
  parameter int W    = 8,
  parameter int INIT = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         dec,
  input  logic [W-1:0] inc,
  output logic [W-1:0] credit,
  output logic [W-1:0] credit_next
);

  localparam logic [W:0] SAT = (W+1)'(INIT);

  logic [W:0] sum_s;

  // Next credit; one spare bit keeps the sum from wrapping before saturation
  always_comb begin
    sum_s = {1'b0, credit} + {1'b0, inc} - {{W{1'b0}}, dec};
    if (sum_s > SAT) begin
      credit_next = SAT[W-1:0];
    end else begin
      credit_next = sum_s[W-1:0];
    end
  end

  // Credit register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit <= SAT[W-1:0];
    end else begin
      credit <= credit_next;
    end
  end

endmodule

// File: rtl/stream2bft_tx.sv
// Stream-to-BFT transmitter: packs user words into BFT packets under credit
// flow control, with single-packet replay. Option macro: STREAM2BFT_TX_STATS_EN.
module stream2bft_tx
  import bft_pkg::*;
#(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 4,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int DEST_LEAF     = 1,
  parameter int DEST_PORT     = 1,
  parameter int SELF_LEAF     = 0,
  parameter int CREDIT_INIT   = 128
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    din_ap_vld,
  output logic                    din_ap_ack,
  input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
`ifdef STREAM2BFT_TX_STATS_EN
  output logic [31:0]             pkt_count,
`endif
  input  logic                    resend
);

  localparam int CW        = NUM_ADDR_BITS + 1;
  localparam int VALID_POS = PACKET_BITS - 1;
  localparam int LEAF_LSB  = VALID_POS - NUM_LEAF_BITS;
  localparam int PORT_LSB  = LEAF_LSB - NUM_PORT_BITS;

  logic                     run_r;
  bft_state_e               state_r;
  bft_state_e               state_next_s;
  logic [NUM_ADDR_BITS-1:0] seq_r;
  logic [PACKET_BITS-1:0]   last_pkt_r;
  logic [PACKET_BITS-1:0]   dout_r;
  logic [PACKET_BITS-1:0]   new_pkt_s;
  logic                     sent_r;
  logic                     accept_s;
  logic                     replay_s;
  logic [CW-1:0]            ret_s;
  logic [CW-1:0]            credit_s;
  logic [CW-1:0]            credit_next_s;
  logic                     unused_ok_s;

  // Reset release is retimed to clk; nothing is accepted until this flop rises
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Credit-return decode: valid packet addressed to our leaf's control port
  always_comb begin
    if (din_leaf_bft2interface[VALID_POS] &&
        din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS] == NUM_LEAF_BITS'(SELF_LEAF) &&
        din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(BFT_CTRL_PORT)) begin
      ret_s = din_leaf_bft2interface[CW-1:0];
    end else begin
      ret_s = CW'(0);
    end
  end

  assign unused_ok_s = ^din_leaf_bft2interface[PORT_LSB-1:CW];

  assign replay_s   = run_r & resend & sent_r;
  assign accept_s   = run_r & din_ap_vld & ~resend & (state_r == ST_SEND) &
                      (credit_s != CW'(0));
  assign din_ap_ack = accept_s;
  assign new_pkt_s  = {1'b1, NUM_LEAF_BITS'(DEST_LEAF), NUM_PORT_BITS'(DEST_PORT),
                       seq_r, 1'b0, din};

  bft_credit_counter #(
    .W    (CW),
    .INIT (CREDIT_INIT)
  ) u_credit (
    .clk         (clk),
    .reset_n     (reset_n),
    .dec         (accept_s),
    .inc         (ret_s),
    .credit      (credit_s),
    .credit_next (credit_next_s)
  );

  // FSM next state; a replay request overrides whatever state we are in
  always_comb begin
    state_next_s = state_r;
    if (replay_s) begin
      state_next_s = ST_REPLAY;
    end else begin
      case (state_r)
        ST_SEND, ST_REPLAY: begin
          if (credit_next_s == CW'(0)) begin
            state_next_s = ST_WAIT_CREDIT;
          end else begin
            state_next_s = ST_SEND;
          end
        end
        ST_WAIT_CREDIT: begin
          if (credit_next_s != CW'(0)) begin
            state_next_s = ST_SEND;
          end else begin
            state_next_s = ST_WAIT_CREDIT;
          end
        end
        default: state_next_s = ST_SEND;
      endcase
    end
  end

  // Packet datapath: new word, replay of the last packet, or idle zeros
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_SEND;
      seq_r      <= NUM_ADDR_BITS'(0);
      last_pkt_r <= PACKET_BITS'(0);
      sent_r     <= 1'b0;
      dout_r     <= PACKET_BITS'(0);
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        seq_r      <= seq_r + NUM_ADDR_BITS'(1);
        last_pkt_r <= new_pkt_s;
        sent_r     <= 1'b1;
        dout_r     <= new_pkt_s;
      end else if (replay_s) begin
        dout_r <= last_pkt_r;
      end else begin
        dout_r <= PACKET_BITS'(0);
      end
    end
  end

  assign dout_leaf_interface2bft = dout_r;

`ifdef STREAM2BFT_TX_STATS_EN
  logic [31:0] pkt_count_r;

  // Emitted-packet counter, replays included
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count_r <= 32'd0;
    end else if (accept_s || replay_s) begin
      pkt_count_r <= pkt_count_r + 32'd1;
    end else begin
      pkt_count_r <= pkt_count_r;
    end
  end

  assign pkt_count = pkt_count_r;
`endif

endmodule

// File: tb/tb_stream2bft_tx.sv
// Self-checking bench for stream2bft_tx against a cycle-level behavioural model.
module tb_stream2bft_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] din = 32'd0;
  logic        vld = 1'b0;
  logic        ack;
  logic [48:0] rp = 49'd0;
  logic [48:0] dout;
  logic        resend = 1'b0;
`ifdef STREAM2BFT_TX_STATS_EN
  logic [31:0] pkt_count;
`endif

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int          m_credit;
  int          m_seq;
  logic [48:0] m_last;
  bit          m_sent;
  bit          m_replay;
  bit          m_run;
  int          m_count;
  int          n_ack;

  always #5 clk = ~clk;

  stream2bft_tx dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .din                     (din),
    .din_ap_vld              (vld),
    .din_ap_ack              (ack),
    .din_leaf_bft2interface  (rp),
    .dout_leaf_interface2bft (dout),
`ifdef STREAM2BFT_TX_STATS_EN
    .pkt_count               (pkt_count),
`endif
    .resend                  (resend)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 128; m_seq = 0; m_last = 49'd0; m_sent = 0;
    m_replay = 0; m_run = 0; m_count = 0;
  endtask

  function automatic logic [48:0] ret_pkt(input int cnt);
    logic [23:0] junk;
    junk = 24'($urandom);
    return {1'b1, 4'd0, 4'd0, 7'($urandom), 1'b0, junk, 8'(cnt)};
  endfunction

  // One clock: drive at negedge, check ack before the edge, dout after it
  task automatic cycle(input logic v, input logic [31:0] d, input logic rs, input logic [48:0] p);
    bit          exp_ack;
    int          ret;
    logic [48:0] exp_dout;
    @(negedge clk);
    vld = v; din = d; resend = rs; rp = p;
    #1;
    exp_ack = m_run && v && !rs && (m_credit > 0) && !m_replay;
    chk("ack", 64'(ack), 64'(exp_ack));
    @(posedge clk);
    #1;
    ret = (p[48] && p[47:44] == 4'd0 && p[43:40] == 4'd0) ? int'(p[7:0]) : 0;
    if (exp_ack) begin
      exp_dout = {1'b1, 4'd1, 4'd1, 7'(m_seq), 1'b0, d};
      m_last = exp_dout;
      m_seq = (m_seq + 1) % 128;
      m_sent = 1;
      m_count++;
      n_ack++;
    end else if (m_run && rs && m_sent) begin
      exp_dout = m_last;
      m_count++;
    end else begin
      exp_dout = 49'd0;
    end
    m_replay = m_run && rs && m_sent;
    m_credit = m_credit - (exp_ack ? 1 : 0) + ret;
    if (m_credit > 128) m_credit = 128;
    m_run = 1;
    chk("dout", 64'(dout), 64'(exp_dout));
`ifdef STREAM2BFT_TX_STATS_EN
    chk("pkt_count", 64'(pkt_count), 64'(m_count));
`endif
  endtask

  // Reset with garbage on the inputs; release just after a rising edge
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; vld = 1'b1; resend = 1'b1; din = $urandom; rp = ret_pkt(5);
    #1;
    chk("rst_ack", 64'(ack), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_dout", 64'(dout), 64'd0);
`ifdef STREAM2BFT_TX_STATS_EN
    chk("rst_count", 64'(pkt_count), 64'd0);
`endif
    @(posedge clk);
    #1;
    vld = 1'b0; resend = 1'b0; rp = 49'd0;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    n_ack = 0;

    // Basic stream, first cycle after release must not accept
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hDEADBEEF, 1'b0, 49'd0);
    chk("three_acks", 64'(n_ack), 64'd3);
    cycle(1'b0, 32'd0, 1'b0, 49'd0);

    // Resend before anything sent is ignored; then replay of seq 5
    do_reset();
    cycle(1'b1, 32'h11111111, 1'b1, 49'd0);
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 49'd0);
    cycle(1'b1, 32'h12345678, 1'b0, 49'd0);
    chk("seq5", 64'(dout[39:33]), 64'd5);
    cycle(1'b1, 32'hCAFEF00D, 1'b1, 49'd0);
    chk("replay_pkt", 64'(dout), 64'({1'b1, 4'd1, 4'd1, 7'd5, 1'b0, 32'h12345678}));
    cycle(1'b1, 32'h0BADF00D, 1'b0, 49'd0);
    cycle(1'b1, 32'h600D600D, 1'b0, 49'd0);
    chk("seq6", 64'(dout[39:33]), 64'd6);

    // Saturation at 100+64, exhaustion, wrap, and simultaneous accept/return
    do_reset();
    cycle(1'b0, 32'd0, 1'b0, 49'd0);
    for (int i = 0; i < 28; i++) cycle(1'b1, $urandom, 1'b0, 49'd0);
    cycle(1'b0, 32'd0, 1'b0, ret_pkt(64));
    n_ack = 0;
    for (int i = 0; i < 132; i++) cycle(1'b1, $urandom, 1'b0, 49'd0);
    chk("sat_acks", 64'(n_ack), 64'd128);
    chk("ack_stall", 64'(ack), 64'd0);
    n_ack = 0;
    cycle(1'b1, $urandom, 1'b0, ret_pkt(2));
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 49'd0);
    chk("ret2_acks", 64'(n_ack), 64'd2);
    cycle(1'b0, 32'd0, 1'b0, ret_pkt(1));
    n_ack = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, ret_pkt(1));
    chk("same_cycle_acks", 64'(n_ack), 64'd3);

    // Random soak: returns (matching and foreign), resends, bursts
    for (int i = 0; i < 400; i++) begin
      logic [48:0] p;
      int r;
      r = int'($urandom_range(99, 0));
      if (r < 8) p = ret_pkt(int'($urandom_range(20, 0)));
      else if (r < 10) p = ret_pkt(64);
      else if (r < 13) p = {1'b1, 4'd2, 4'd0, 40'd9};
      else if (r < 16) p = {1'b1, 4'd0, 4'd3, 40'd9};
      else if (r < 19) p = {1'b0, 4'd0, 4'd0, 40'd9};
      else p = 49'd0;
      cycle($urandom_range(3, 0) != 0, $urandom, $urandom_range(19, 0) == 0, p);
    end

    // Reset asserted while a word is being acknowledged: it must vanish
    @(negedge clk);
    vld = 1'b1; din = 32'hA5A5A5A5; resend = 1'b0; rp = 49'd0;
    #1;
    chk("pre_rst_ack", 64'(ack), 64'(m_credit > 0 && !m_replay));
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ack", 64'(ack), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_dout", 64'(dout), 64'd0);
    @(posedge clk);
    #1;
    vld = 1'b0;
    reset_n = 1'b1;
    model_reset();
    n_ack = 0;
    for (int i = 0; i < 131; i++) cycle(1'b1, $urandom, 1'b0, 49'd0);
    chk("post_rst_acks", 64'(n_ack), 64'd128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream2bft_tx.md
STREAM2BFT_TX -- requirements
Module: stream2bft_tx

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 49, total BFT packet width.
REQ-002 SHALL have parameter PAYLOAD_BITS, default 32, user data width.
REQ-003 SHALL have parameter NUM_LEAF_BITS, default 4, leaf address width.
REQ-004 SHALL have parameter NUM_PORT_BITS, default 4, port address width.
REQ-005 SHALL have parameter NUM_ADDR_BITS, default 7, sequence-number and credit-count width.
REQ-006 SHALL have parameters DEST_LEAF (default 1), DEST_PORT (default 1) and SELF_LEAF (default 0), giving the target leaf, the target port and this leaf's own address.
REQ-007 SHALL have parameter CREDIT_INIT, default 128, receiver buffer depth in packets.
REQ-008 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port din, input, PAYLOAD_BITS, user stream data.
REQ-011 SHALL have port din_ap_vld, input, 1, user data valid.
REQ-012 SHALL have port din_ap_ack, output, 1, data-accepted strobe.
REQ-013 SHALL have port din_leaf_bft2interface, input, PACKET_BITS, incoming credit-return packets.
REQ-014 SHALL have port dout_leaf_interface2bft, output, PACKET_BITS, outgoing packets.
REQ-015 SHALL have port resend, input, 1, replay-last-packet request.

Function
REQ-016 Outgoing packet layout SHALL be: [48] valid, [47:44] DEST_LEAF, [43:40] DEST_PORT, [39:33] seq, [32] 0, [31:0] payload.
REQ-017 din_ap_ack SHALL be combinational and high in a cycle iff din_ap_vld=1, state=SEND, credit>0 and resend=0; din is captured on that edge.
REQ-018 Accepted word SHALL appear on dout_leaf_interface2bft the next cycle for exactly one cycle with valid=1; dout SHALL be all-zero in every other cycle.
REQ-019 Sustained throughput SHALL be one packet per cycle while credit>0.
REQ-020 seq SHALL start at 0, increment per new packet and wrap modulo 2^NUM_ADDR_BITS (127 to 0).
REQ-021 Credit return SHALL be an incoming packet with valid=1, leaf=SELF_LEAF, port=0; payload[NUM_ADDR_BITS:0] is the number of freed slots.
REQ-022 Credit SHALL update as credit - accept + returned, saturating at CREDIT_INIT; simultaneous accept and return SHALL apply in the same cycle.
REQ-023 FSM states SHALL be SEND, WAIT_CREDIT and REPLAY.
REQ-024 FSM SHALL move SEND to WAIT_CREDIT when credit reaches 0; WAIT_CREDIT to SEND when credit>0; any state to REPLAY on resend=1 once a packet has been sent; REPLAY to SEND (or to WAIT_CREDIT if credit=0) after one cycle.
REQ-025 In REPLAY the last emitted packet SHALL be re-emitted bit-identical (same seq), consuming no credit and not advancing seq.
REQ-026 resend before the first packet has been sent SHALL be ignored.
REQ-027 resend coinciding with din_ap_vld SHALL take priority: ack stays low and the replay is emitted.

Reset
REQ-028 While reset_n=0 the block SHALL hold: din_ap_ack=0, dout=0, credit=CREDIT_INIT, seq=0, state=SEND, last-packet register cleared, sent-flag=0.
REQ-029 Reset asserted mid-transfer SHALL drop any captured, unsent word without emitting it.
REQ-030 Reset SHALL be released synchronously to clk internally; an input asserted on the deassertion edge SHALL first be accepted one cycle later.

Configuration
REQ-031 With macro STREAM2BFT_TX_STATS_EN defined, the block SHALL add output pkt_count [31:0], which counts every emitted packet including replays, wraps at 2^32 and resets to 0.
REQ-032 Without STREAM2BFT_TX_STATS_EN the port and its counter SHALL be absent, with function otherwise identical.

Structure
REQ-033 Shared package bft_pkg SHALL hold the packet field offsets and widths, the control-port constant 0 and the FSM state enum.
REQ-034 The credit counter (saturating add/subtract) SHALL be a sub-module named bft_credit_counter.

Verification
REQ-035 Reset, then din=0xDEADBEEF held with vld for 3 cycles -> 3 acks; packets carry seq 0,1,2; dout bit48=1 each cycle after its ack.
REQ-036 CREDIT_INIT=4 with vld held -> 4 acks, then ack=0 and WAIT_CREDIT; return packet with count=2 -> 2 more acks.
REQ-037 After packet seq=5 payload=0x12345678, pulse resend with vld=1 -> no ack that cycle; identical packet re-emitted; credit unchanged; next new packet has seq=6.
REQ-038 Send 130 packets with periodic count=64 returns -> seq wraps 127 to 0; credit never exceeds 128; return of 64 at credit=100 -> credit=128.
REQ-039 Accept and count=1 return in the same cycle at credit=1 -> credit stays 1, no stall.
REQ-040 Assert reset_n=0 one cycle after an ack -> no packet emitted; after release credit=128 and seq=0.
